// File: rtl/sar_seq_ctrl.sv
// Successive-approximation sequencer: sample phase followed by an MSB-first
// binary search, driving the DAC trial code, comparator strobe and clock select.
module sar_seq_ctrl #(
   parameter int NBITS         = 8,
   parameter int SAMPLE_CYCLES = 2,
   parameter int CMP_WAIT      = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_out,
   output logic             busy,
   output logic             sample_en,
   output logic             clk_sel,
   output logic             cmp_strobe,
   output logic [NBITS-1:0] dac_code,
   output logic [NBITS-1:0] result,
   output logic             result_valid
);

   localparam int CNT_MAX = (SAMPLE_CYCLES > CMP_WAIT) ? SAMPLE_CYCLES - 1 : CMP_WAIT - 1;
   localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam int BW      = $clog2(NBITS);

   localparam logic [CW-1:0] SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_LOAD   = CW'((CMP_WAIT > 0) ? CMP_WAIT - 1 : 0);
   localparam logic [BW-1:0] TOP_BIT     = BW'(NBITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      SETTLE,
      COMPARE,
      DONE
   } state_t;

   state_t           r_state;
   state_t           w_stateNext;
   state_t           w_waitState;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cntNext;
   logic [BW-1:0]    r_bitIdx;
   logic [BW-1:0]    w_bitIdxNext;
   logic [NBITS-1:0] r_dacCode;
   logic [NBITS-1:0] w_dacNext;
   logic [NBITS-1:0] r_result;
   logic [NBITS-1:0] w_resultNext;

   // With no settle time each trial bit goes straight to its compare cycle.
   assign w_waitState = (CMP_WAIT == 0) ? COMPARE : SETTLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bitIdx  <= '0;
         r_dacCode <= '0;
         r_result  <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_cnt     <= w_cntNext;
         r_bitIdx  <= w_bitIdxNext;
         r_dacCode <= w_dacNext;
         r_result  <= w_resultNext;
      end
   end

   always_comb begin
      w_stateNext  = r_state;
      w_cntNext    = r_cnt;
      w_bitIdxNext = r_bitIdx;
      w_dacNext    = r_dacCode;
      w_resultNext = r_result;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_stateNext = SAMPLE;
               w_cntNext   = SAMPLE_LOAD;
               w_dacNext   = '0;
            end
         end
         SAMPLE: begin
            if (r_cnt == '0) begin
               w_bitIdxNext = TOP_BIT;
               w_dacNext    = {1'b1, {(NBITS-1){1'b0}}};
               w_cntNext    = WAIT_LOAD;
               w_stateNext  = w_waitState;
            end else begin
               w_cntNext = r_cnt - 1'b1;
            end
         end
         SETTLE: begin
            if (r_cnt == '0) begin
               w_stateNext = COMPARE;
            end else begin
               w_cntNext = r_cnt - 1'b1;
            end
         end
         COMPARE: begin
            // Comparator low means the trial overshot Vin, so the bit is dropped.
            if (!cmp_out) begin
               w_dacNext[r_bitIdx] = 1'b0;
            end
            if (r_bitIdx != '0) begin
               w_dacNext[r_bitIdx - BW'(1)] = 1'b1;
               w_bitIdxNext = r_bitIdx - BW'(1);
               w_cntNext    = WAIT_LOAD;
               w_stateNext  = w_waitState;
            end else begin
               w_resultNext = w_dacNext;
               w_stateNext  = DONE;
            end
         end
         DONE: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   assign busy         = (r_state == SAMPLE) || (r_state == SETTLE) || (r_state == COMPARE);
   assign sample_en    = (r_state == SAMPLE);
   assign clk_sel      = (r_state == SAMPLE);
   assign cmp_strobe   = (r_state == COMPARE);
   assign result_valid = (r_state == DONE);
   assign dac_code     = r_dacCode;
   assign result       = r_result;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench for sar_seq_ctrl: default 8-bit instance driven by a
// comparator model and a small 4-bit instance with no settle cycles.
module tb_sar_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cmp_out;
   logic       busy, sample_en, clk_sel, cmp_strobe, result_valid;
   logic [7:0] dac_code, result;
   logic [7:0] vin = 8'h00;
   int         cmpMode = 0;

   logic       start4 = 1'b0;
   logic       cmp4;
   logic       busy4, sampleEn4, clkSel4, cmpStrobe4, resultValid4;
   logic [3:0] dac4, result4;

   int errCount = 0;
   int checkCount = 0;
   int cyc = 0;
   int strobeCount = 0;

   typedef struct {
      logic [7:0] code;
      int         cyc;
   } exp_t;
   exp_t expQ[$];

   logic [7:0] trials[8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

   // Comparator model: mode 0 compares against Vin, 1 and 2 tie the decision.
   assign cmp_out = (cmpMode == 1) ? 1'b1 : (cmpMode == 2) ? 1'b0 : (vin >= dac_code);
   assign cmp4    = (4'h9 >= dac4);

   sar_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmp_out(cmp_out),
      .busy(busy), .sample_en(sample_en), .clk_sel(clk_sel), .cmp_strobe(cmp_strobe),
      .dac_code(dac_code), .result(result), .result_valid(result_valid)
   );

   sar_seq_ctrl #(.NBITS(4), .SAMPLE_CYCLES(1), .CMP_WAIT(0)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .cmp_out(cmp4),
      .busy(busy4), .sample_en(sampleEn4), .clk_sel(clkSel4), .cmp_strobe(cmpStrobe4),
      .dac_code(dac4), .result(result4), .result_valid(resultValid4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Scoreboard side: every result_valid must match the oldest expected conversion.
   always @(negedge clk) begin
      exp_t e;
      if (cmp_strobe) strobeCount++;
      if (result_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedValid", 32'd1, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("result", 32'(result), 32'(e.code));
            checkOutput("validCycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] v, input int mode, input logic [7:0] expCode,
                                input bit doPush);
      exp_t e;
      vin = v;
      cmpMode = mode;
      @(negedge clk);
      start = 1'b1;
      strobeCount = 0;
      if (doPush) begin
         e.code = expCode;
         e.cyc  = cyc + 19;
         expQ.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_sampleEn"}, 32'(sample_en), 32'd0);
      checkOutput({tag, "_clkSel"}, 32'(clk_sel), 32'd0);
      checkOutput({tag, "_strobe"}, 32'(cmp_strobe), 32'd0);
      checkOutput({tag, "_valid"}, 32'(result_valid), 32'd0);
      checkOutput({tag, "_dac"}, 32'(dac_code), 32'd0);
      checkOutput({tag, "_result"}, 32'(result), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      exp_t e;
      bit expStrobe;

      // Reset state
      #12;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Vin=0xA5 with cycle-by-cycle control and trial-code checks
      applyStimulus(8'hA5, 0, 8'hA5, 1'b1);
      for (int k = 1; k <= 19; k++) begin
         expStrobe = (k >= 4) && (k <= 18) && (k % 2 == 0);
         checkOutput("busy", 32'(busy), 32'(k <= 18));
         checkOutput("sampleEn", 32'(sample_en), 32'(k <= 2));
         checkOutput("clkSel", 32'(clk_sel), 32'(k <= 2));
         checkOutput("strobe", 32'(cmp_strobe), 32'(expStrobe));
         if (expStrobe) checkOutput("trialCode", 32'(dac_code), 32'(trials[(k - 4) / 2]));
         @(negedge clk);
      end
      checkOutput("pendingA5", 32'(expQ.size()), 32'd0);
      checkOutput("strobesA5", 32'(strobeCount), 32'd8);

      // Comparator tied high, then tied low
      applyStimulus(8'h00, 1, 8'hFF, 1'b1);
      repeat (20) @(negedge clk);
      checkOutput("pendingFF", 32'(expQ.size()), 32'd0);
      checkOutput("strobesFF", 32'(strobeCount), 32'd8);
      applyStimulus(8'h00, 2, 8'h00, 1'b1);
      repeat (20) @(negedge clk);
      checkOutput("pending00", 32'(expQ.size()), 32'd0);
      checkOutput("strobes00", 32'(strobeCount), 32'd8);

      // Start held high: back-to-back conversions every 20 cycles
      vin = 8'h3C;
      cmpMode = 0;
      @(negedge clk);
      start = 1'b1;
      c = cyc;
      for (int n = 0; n < 3; n++) begin
         e.code = 8'h3C;
         e.cyc  = c + 19 + 20 * n;
         expQ.push_back(e);
      end
      repeat (59) @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("pendingHeld", 32'(expQ.size()), 32'd0);

      // Start re-pulsed mid-conversion must be ignored
      applyStimulus(8'h5A, 0, 8'h5A, 1'b1);
      for (int k = 1; k <= 25; k++) begin
         start = (k == 5) || ((k >= 10) && (k <= 17));
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("pendingIgnore", 32'(expQ.size()), 32'd0);

      // Reset at cycle 10 aborts the conversion asynchronously
      applyStimulus(8'h77, 0, 8'h77, 1'b0);
      repeat (9) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("midReset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      applyStimulus(8'h5A, 0, 8'h5A, 1'b1);
      repeat (20) @(negedge clk);
      checkOutput("pendingAfterReset", 32'(expQ.size()), 32'd0);

      // Small instance: 4 bits, one sample cycle, no settle
      @(negedge clk);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         checkOutput("sampleEn4", 32'(sampleEn4), 32'(k == 1));
         checkOutput("clkSel4", 32'(clkSel4), 32'(k == 1));
         checkOutput("valid4", 32'(resultValid4), 32'(k == 6));
         if (k == 6) checkOutput("result4", 32'(result4), 32'h9);
         @(negedge clk);
      end

      checkOutput("finalQueue", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/sar_seq_ctrl.md
# sar_seq_ctrl

Successive-approximation sequencer for the SAR clock-generation path. On `start` it runs a sample phase, then an MSB-first binary search of `NBITS` comparator decisions. It drives the DAC trial code, the comparator strobe, and the `clk_sel` select line consumed by the downstream clock/data mux. It returns the converted code with a one-cycle valid pulse.

## Interface
- `NBITS`, default 8: conversion resolution; legal values are ≥ 2.
- `SAMPLE_CYCLES`, default 2: length of the sample phase in cycles; legal values are ≥ 1.
- `CMP_WAIT`, default 1: DAC settle cycles before each comparator strobe; legal values are ≥ 0, and 0 skips SETTLE.
- `clk  input  1`: single clock; all logic is on the rising edge.
- `rst_n  input  1`: reset, asynchronous and active-low.
- `start  input  1`: conversion request; accepted only in IDLE.
- `cmp_out  input  1`: comparator decision; 1 means Vin ≥ Vdac; sampled on the edge that ends a COMPARE cycle.
- `busy  output  1`: high from the first SAMPLE cycle through the last COMPARE cycle.
- `sample_en  output  1`: track/hold control; high during SAMPLE only.
- `clk_sel  output  1`: select for the downstream mux; 1 selects the sample-phase source (SAMPLE), 0 selects the conversion source.
- `cmp_strobe  output  1`: one-cycle comparator clock pulse, high in each COMPARE cycle.
- `dac_code  output  NBITS`: current trial code.
- `result  output  NBITS`: last completed conversion; held until the next DONE.
- `result_valid  output  1`: one-cycle pulse in DONE.

## Operation
- All outputs are registered Moore outputs decoded from the state plus datapath registers.
- States are IDLE, SAMPLE, SETTLE, COMPARE and DONE.
- IDLE:
  - busy, sample_en, clk_sel and cmp_strobe are 0.
  - `start`=1 → SAMPLE; the counter loads SAMPLE_CYCLES-1 and dac_code is cleared to 0.
- SAMPLE:
  - sample_en=1, clk_sel=1, busy=1.
  - The counter decrements each cycle.
  - When the counter is 0: bit_idx←NBITS-1, dac_code←1<<(NBITS-1), counter←CMP_WAIT-1. Next state is SETTLE, or COMPARE if CMP_WAIT=0.
- SETTLE: busy=1 and the counter decrements; at 0 → COMPARE.
- COMPARE:
  - cmp_strobe=1, busy=1.
  - On the closing edge, if cmp_out=0 then dac_code[bit_idx]←0; otherwise the bit is kept.
  - If bit_idx>0: dac_code[bit_idx-1]←1, bit_idx decrements, counter←CMP_WAIT-1, then → SETTLE (or COMPARE if CMP_WAIT=0).
  - If bit_idx=0: result←final dac_code, then → DONE.
- DONE: result_valid=1 and busy=0, then → IDLE unconditionally. dac_code holds the final code.
- `start` outside IDLE is ignored. There is no queuing.
- Holding `start` high continuously gives back-to-back conversions, each separated by one IDLE cycle.
- Counters and bit_idx are sized `$clog2` of their maximum value plus 1. No wrap occurs within legal parameters.
- Reset (rst_n=0, any time including mid-conversion):
  - State → IDLE immediately.
  - busy, sample_en, clk_sel, cmp_strobe, result_valid, dac_code and result all go to 0.
  - Operation resumes on the first rising edge after release.

## Timing
- Cycle 0 is the IDLE cycle in which `start`=1 is sampled.
- SAMPLE occupies cycles 1..SAMPLE_CYCLES.
- Each bit takes CMP_WAIT SETTLE cycles followed by 1 COMPARE cycle.
- result_valid is high in cycle SAMPLE_CYCLES + NBITS·(CMP_WAIT+1) + 1. With defaults that is cycle 19.
- Conversion period with start held high is that value + 1; with defaults, 20 cycles.
- dac_code changes only on edges leaving SAMPLE or COMPARE. It is stable for the whole SETTLE and COMPARE window of each bit.
- clk_sel falls on the same edge that sample_en falls, so there is never an overlap with cmp_strobe.
- cmp_strobe pulses exactly NBITS times per conversion.

## Test plan
- Comparator model cmp_out=(Vin ≥ dac_code), defaults, Vin=0xA5, single start pulse:
  - Trial codes are 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - result=0xA5 with result_valid high exactly in cycle 19.
  - busy is high for cycles 1..18.
- cmp_out tied to 1 → result=0xFF. cmp_out tied to 0 → result=0x00. In both cases, exactly 8 cmp_strobe pulses.
- start held high with Vin=0x3C → result_valid pulses every 20 cycles, each with result=0x3C.
- start pulsed again during cycles 1..18 → ignored; a single result_valid at cycle 19.
- rst_n pulled low at cycle 10 →
  - All outputs are 0 asynchronously.
  - No result_valid occurs.
  - A new start after release converts Vin=0x5A to result 0x5A in 19 cycles.
- NBITS=4, SAMPLE_CYCLES=1, CMP_WAIT=0, Vin=0x9 → result=0x9 at cycle 6. sample_en/clk_sel are high only in cycle 1.
